// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES key-path blocks:
//   eic_mode_e      - per-key column transform mode
//   state_e         - control states of the column engine
//   GF_POLY         - AES field polynomial x^8+x^4+x^3+x+1
//   gf_xtime        - multiply by x (0x02) in GF(2^8)
//   gf_mul          - general GF(2^8) product, always reduced to 8 bits
//   eic_decode_mode - raw 2-bit mode to eic_mode_e (reserved -> bypass)
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        EIC_BYPASS = 2'b00,
        EIC_INV    = 2'b01,
        EIC_FWD    = 2'b10
    } eic_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [8:0] GF_POLY = 9'h11B;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ GF_POLY[7:0]) : {a[6:0], 1'b0};
    endfunction

    // Shift-and-add product; with a constant coefficient this folds down
    // to a handful of xtime/XOR terms.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] pw;
        // NOTE: blocking assignments are correct here: these are local
        // temporaries evaluated in order, not clocked state.
        acc = 8'h00;
        pw  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ pw;
            pw = gf_xtime(pw);
        end
        return acc;
    endfunction

    function automatic eic_mode_e eic_decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return EIC_INV;
            2'b10:   return EIC_FWD;
            default: return EIC_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/eic_mixcol.sv
// ---------------------------------------------------------------------------
// eic_mixcol
// Combinational single-column transform.
//   mode    in  : EIC_INV -> InvMixColumns, EIC_FWD -> MixColumns,
//                 anything else passes the column through
//   col_in  in  : column, byte 0 = [31:24]
//   col_out out : transformed column, same byte order
// ---------------------------------------------------------------------------
module eic_mixcol
    import aes_pkg::*;
(
    input  eic_mode_e   mode,
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0]  a     [4];
    logic [31:0] inv_col;
    logic [31:0] fwd_col;

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign a[r] = col_in[31-8*r -: 8];

        // Row r uses the matrix row rotated right by r.
        assign inv_col[31-8*r -: 8] = gf_mul(a[r],       8'h0e) ^
                                      gf_mul(a[(r+1)%4], 8'h0b) ^
                                      gf_mul(a[(r+2)%4], 8'h0d) ^
                                      gf_mul(a[(r+3)%4], 8'h09);

        assign fwd_col[31-8*r -: 8] = gf_xtime(a[r]) ^
                                      gf_xtime(a[(r+1)%4]) ^ a[(r+1)%4] ^
                                      a[(r+2)%4] ^ a[(r+3)%4];
    end

    always_comb begin
        // NOTE: the default branch assigns col_out on every path, so this
        // stays purely combinational and no latch is inferred.
        case (mode)
            EIC_INV: col_out = inv_col;
            EIC_FWD: col_out = fwd_col;
            default: col_out = col_in;
        endcase
    end

endmodule

// File: rtl/eic_key_mixer.sv
// ---------------------------------------------------------------------------
// eic_key_mixer
// Sequential round-key column transformer for the equivalent inverse cipher.
// Accepts one 128-bit key per handshake, applies bypass / InvMixColumns /
// MixColumns to its four columns, LANES columns per cycle.
//   LANES     : columns per cycle (1, 2 or 4)
//   TAG_W     : sideband tag width
//   in_valid  / in_ready  : input handshake
//   in_key    : key, word 0 = [127:96], byte 0 of a word = [31:24]
//   in_mode   : 00 bypass, 01 inverse, 10 forward, 11 treated as bypass
//   in_tag    : tag carried through unchanged
//   out_valid / out_ready : output handshake
//   out_key   : transformed key, out_tag : tag captured with it
// ---------------------------------------------------------------------------
module eic_key_mixer
    import aes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_key,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_key,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NGRP  = 4 / LANES;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_check
        $error("eic_key_mixer: LANES must be 1, 2 or 4");
    end

    state_e           state;
    logic [GRP_W-1:0] grp;
    logic [31:0]      col_q [4];
    eic_mode_e        mode_q;
    logic [TAG_W-1:0] tag_q;

    eic_mode_e        in_mode_dec;
    logic             accept;

    logic [1:0]       lane_idx [LANES];
    logic [31:0]      lane_src [LANES];
    logic [31:0]      lane_dst [LANES];

    assign in_mode_dec = eic_decode_mode(in_mode);
    assign in_ready    = (state == IDLE) || (state == DONE && out_ready);
    assign accept      = in_valid && in_ready;

    // Lane l works on column grp*LANES + l of the current group.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 2'(int'(grp) * LANES + l);
        assign lane_src[l] = col_q[lane_idx[l]];

        eic_mixcol u_mixcol (
            .mode    (mode_q),
            .col_in  (lane_src[l]),
            .col_out (lane_dst[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grp    <= '0;
            mode_q <= EIC_BYPASS;
            tag_q  <= '0;
            // NOTE: the column store is reset because out_key must read
            // zero after reset; it is only four words, so this is cheap.
            for (int w = 0; w < 4; w++) col_q[w] <= '0;
        end else if (accept) begin
            // Covers both a fresh accept in IDLE and a drain+accept in DONE.
            for (int w = 0; w < 4; w++) col_q[w] <= in_key[127-32*w -: 32];
            mode_q <= in_mode_dec;
            tag_q  <= in_tag;
            grp    <= '0;
            state  <= (in_mode_dec == EIC_BYPASS) ? DONE : BUSY;
        end else begin
            case (state)
                BUSY: begin
                    for (int l = 0; l < LANES; l++) col_q[lane_idx[l]] <= lane_dst[l];
                    if (grp == LAST_GRP) begin
                        state <= DONE;
                        grp   <= '0;
                    end else begin
                        grp <= grp + GRP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign out_key   = {col_q[0], col_q[1], col_q[2], col_q[3]};
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_eic_key_mixer.sv
// ---------------------------------------------------------------------------
// tb_eic_key_mixer
// Three instances (LANES = 1, 2, 4) share clock and reset. Directed vectors,
// backpressure, mid-BUSY reset and randomized streaming are compared against
// a matrix-product reference model over GF(2^8).
// ---------------------------------------------------------------------------
module tb_eic_key_mixer;

    localparam int TAG_W = 4;
    localparam int NDUT  = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid  [NDUT];
    logic             in_ready  [NDUT];
    logic [127:0]     in_key    [NDUT];
    logic [1:0]       in_mode   [NDUT];
    logic [TAG_W-1:0] in_tag    [NDUT];
    logic             out_valid [NDUT];
    logic             out_ready [NDUT];
    logic [127:0]     out_key   [NDUT];
    logic [TAG_W-1:0] out_tag   [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        eic_key_mixer #(.LANES(1 << gi), .TAG_W(TAG_W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_key    (in_key[gi]),
            .in_mode   (in_mode[gi]),
            .in_tag    (in_tag[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_key   (out_key[gi]),
            .out_tag   (out_tag[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int x;
        int p;
        x = int'(a);
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11B;
        end
        return p[7:0];
    endfunction

    // Each output byte r of column c = sum_j M[r][j] * a_j, M circulant.
    function automatic logic [127:0] ref_mix(input logic [127:0] key, input logic [1:0] mode);
        int          coef [4];
        logic [127:0] res;
        logic [7:0]  acc;
        if (mode == 2'b01)      coef = '{14, 11, 13, 9};
        else if (mode == 2'b10) coef = '{2, 3, 1, 1};
        else return key;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ ref_mul(key[127-32*c-8*j -: 8], 8'(coef[(j - r + 4) % 4]));
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic int exp_lat(input int i, input logic [1:0] mode);
        return (mode == 2'b01 || mode == 2'b10) ? 1 + 4 / (1 << i) : 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic run_one(input int i, input logic [127:0] key, input logic [1:0] mode,
                           input logic [TAG_W-1:0] tag, input logic [127:0] exp_key,
                           input string name);
        int lat;
        @(negedge clk);
        in_valid[i] = 1'b1;
        in_key[i]   = key;
        in_mode[i]  = mode;
        in_tag[i]   = tag;
        #1;
        check({name, "_in_ready"}, 128'(in_ready[i]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        lat = 1;
        while (!out_valid[i] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(exp_lat(i, mode)));
        check({name, "_key"}, out_key[i], exp_key);
        check({name, "_tag"}, 128'(out_tag[i]), 128'(tag));
    endtask

    task automatic stream(input int i, input string name);
        logic [127:0]     q_key [$];
        logic [TAG_W-1:0] q_tag [$];
        logic [127:0]     k;
        logic [1:0]       m;
        logic [TAG_W-1:0] t;
        bit               have;
        int               sent;
        int               got;
        int               cyc;
        have = 1'b0; sent = 0; got = 0; cyc = 0;
        k = '0; m = 2'b00; t = '0;
        while (got < 16 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            out_ready[i] = ($urandom_range(0, 3) != 0);
            if (out_valid[i] && out_ready[i]) begin
                if (q_key.size() == 0) begin
                    check({name, "_extra_output"}, 128'(q_key.size()), 128'd1);
                end else begin
                    check({name, "_key"}, out_key[i], q_key.pop_front());
                    check({name, "_tag"}, 128'(out_tag[i]), 128'(q_tag.pop_front()));
                end
                got++;
            end
            if (!have && sent < 16 && $urandom_range(0, 3) != 0) begin
                k    = {$urandom, $urandom, $urandom, $urandom};
                m    = 2'($urandom_range(0, 3));
                t    = TAG_W'($urandom);
                have = 1'b1;
            end
            in_valid[i] = have;
            in_key[i]   = k;
            in_mode[i]  = m;
            in_tag[i]   = t;
            #1;
            if (have && in_ready[i]) begin
                q_key.push_back(ref_mix(k, m));
                q_tag.push_back(t);
                sent++;
                have = 1'b0;
            end
        end
        @(negedge clk);
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        check({name, "_count"}, 128'(got), 128'd16);
        check({name, "_pending"}, 128'(q_key.size()), 128'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] held_key;
        int           lat;

        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            in_key[i]    = '0;
            in_mode[i]   = 2'b00;
            in_tag[i]    = '0;
            out_ready[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("reset_out_valid_%0d", i), 128'(out_valid[i]), 128'd0);
            check($sformatf("reset_out_key_%0d", i), out_key[i], 128'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("reset_in_ready_%0d", i), 128'(in_ready[i]), 128'd1);

        // Known-answer vectors
        run_one(2, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 2'b01, 4'h3,
                128'hdb135345_f20a225c_01010101_c6c6c6c6, "inv_l4");
        run_one(0, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 2'b10, 4'h7,
                128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, "fwd_l1");
        run_one(1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 2'b01, 4'h1,
                128'hdb135345_f20a225c_01010101_c6c6c6c6, "inv_l2");
        run_one(2, 128'h00112233_44556677_8899aabb_ccddeeff, 2'b00, 4'hA,
                128'h00112233_44556677_8899aabb_ccddeeff, "bypass_l4");
        run_one(2, 128'h00112233_44556677_8899aabb_ccddeeff, 2'b11, 4'hA,
                128'h00112233_44556677_8899aabb_ccddeeff, "reserved_l4");
        run_one(0, 128'h00112233_44556677_8899aabb_ccddeeff, 2'b11, 4'h2,
                128'h00112233_44556677_8899aabb_ccddeeff, "reserved_l1");

        // Backpressure on LANES=4
        @(negedge clk);
        in_valid[2]  = 1'b1;
        in_key[2]    = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        in_mode[2]   = 2'b01;
        in_tag[2]    = 4'h5;
        out_ready[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[2] = 1'b0;
        lat = 1;
        while (!out_valid[2] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 128'(lat), 128'd2);
        held_key = ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 2'b01);
        for (int k = 0; k < 5; k++) begin
            in_valid[2] = 1'b1;
            in_key[2]   = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
            in_mode[2]  = 2'b10;
            in_tag[2]   = 4'h6;
            #1;
            check($sformatf("bp_hold_valid_%0d", k), 128'(out_valid[2]), 128'd1);
            check($sformatf("bp_hold_key_%0d", k), out_key[2], held_key);
            check($sformatf("bp_hold_tag_%0d", k), 128'(out_tag[2]), 128'h5);
            check($sformatf("bp_in_ready_%0d", k), 128'(in_ready[2]), 128'd0);
            @(negedge clk);
        end
        out_ready[2] = 1'b1;
        #1;
        check("bp_release_in_ready", 128'(in_ready[2]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[2] = 1'b0;
        lat = 1;
        while (!out_valid[2] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_next_latency", 128'(lat), 128'd2);
        check("bp_next_key", out_key[2], 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);
        check("bp_next_tag", 128'(out_tag[2]), 128'h6);

        // Reset in the middle of BUSY on LANES=1
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_key[0]   = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        in_mode[0]  = 2'b10;
        in_tag[0]   = 4'h9;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy_out_valid", 128'(out_valid[0]), 128'd0);
        check("rst_busy_out_key", out_key[0], 128'd0);
        check("rst_busy_out_tag", 128'(out_tag[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_busy_in_ready", 128'(in_ready[0]), 128'd1);
        check("rst_busy_no_partial", 128'(out_valid[0]), 128'd0);
        run_one(0, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 2'b10, 4'hC,
                128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, "after_rst_l1");

        // Randomized streaming at each lane count
        stream(0, "stream_l1");
        stream(1, "stream_l2");
        stream(2, "stream_l4");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eic_key_mixer.md
# eic_key_mixer

Sequential, parametrised round-key column transformer for the equivalent inverse cipher key path. It accepts one 128-bit round key over a valid/ready handshake and applies a per-key mode to each 32-bit column: bypass, InvMixColumns, or forward MixColumns. Throughput is set by `LANES`, the number of columns processed per cycle. It sits between the key-expansion store and the decryption round-key RAM, and replaces the fully unrolled four-column combinational transform with an area-scalable engine.

## Interface
- `LANES`, 4: columns transformed per cycle; legal values are 1, 2, 4; any other value is an elaboration error.
- `TAG_W`, 4: width of the sideband tag (round index), carried through unchanged.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, **asynchronous and active-low**.
- `in_valid` in 1: input key present.
- `in_ready` out 1: block can accept a key.
- `in_key` in 128: round key; word 0 = [127:96]; byte 0 of each word = [31:24].
- `in_mode` in 2: 2'b00 bypass, 2'b01 InvMixColumns, 2'b10 MixColumns, 2'b11 reserved (treated as bypass).
- `in_tag` in TAG_W: sideband tag.
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts.
- `out_key` out 128: transformed key, same word and byte order as `in_key`.
- `out_tag` out TAG_W: tag captured with the key.

## Operation
- **States:**
  - `IDLE`: `in_ready=1`.
  - `BUSY`: processes `LANES` columns per cycle.
  - `DONE`: `out_valid=1`.
- **Accept:** `in_valid && in_ready` latches key, mode and tag.
  - Next state is `BUSY` with `grp=0`.
  - If the mode is bypass or reserved, next state is `DONE` and no columns are touched.
- **BUSY:** each cycle, columns `grp*LANES .. grp*LANES+LANES-1` are replaced by their transform and `grp` increments.
  - On the last group (`grp == 4/LANES-1`), the next state is `DONE`.
  - `grp` has width `max(1, $clog2(4/LANES))` and wraps to 0 on entry to `DONE`.
- **Column transform** is in GF(2^8) with polynomial 0x11B.
  - Inverse, output row r: `r0 = e·a0^b·a1^d·a2^9·a3`, rotating cyclically.
  - Forward: `r0 = 2·a0^3·a1^a2^a3`, rotating cyclically.
  - All products are reduced to 8 bits. No intermediate value wider than 8 bits is visible.
- **DONE:** `out_key`/`out_tag` are held stable while `out_valid && !out_ready`.
  - On `out_valid && out_ready`, the next state is `IDLE`.
- **Back-to-back:** `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - A same-cycle output drain plus input accept loads the new key and goes straight to `BUSY`/`DONE` per the new mode.
- **No abort:** `in_valid` deasserting while in `BUSY` has no effect.
- **Reset:** `rst_n` low at any time, including mid-`BUSY`, asynchronously forces:
  - state `IDLE`, `grp=0`;
  - `out_valid=0`, `out_key=0`, `out_tag=0`;
  - `in_ready=1` once `rst_n` is high.
  - No partial result is ever emitted.

## Timing
- Input handshake in cycle c:
  - bypass: `out_valid` in cycle c+1;
  - mix modes: `out_valid` in cycle c+1+4/LANES (LANES=4: c+2; LANES=2: c+3; LANES=1: c+5).
- **Throughput** with `out_ready` tied high:
  - bypass: one key per 1 cycle;
  - mix modes: one key per 1+4/LANES cycles (the `DONE` cycle overlaps the next accept).
- **Registers:** all outputs are registered state or state decode. There is no combinational path from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready` only.
- **Critical path:** `LANES` parallel column transforms feeding the key register.

## Structure
- **Shared `aes_pkg`:**
  - `eic_mode_e` enum (`EIC_BYPASS`, `EIC_INV`, `EIC_FWD`);
  - `GF_POLY = 9'h11B`;
  - functions `gf_xtime`, `gf_mul`;
  - `state_e` (`IDLE`, `BUSY`, `DONE`).
- **One sub-module:** `eic_mixcol`, a combinational single-column transform with a mode input. It is instantiated `LANES` times via `generate`, with a mux selecting source and destination columns by `grp`.

## Test plan
- **Inverse, LANES=4:** `in_key = 8e4da1bc_9fdc589d_01010101_c6c6c6c6`, mode 01 → `out_key = db135345_f20a225c_01010101_c6c6c6c6` with `out_valid` 2 cycles after accept.
- **Forward, LANES=1:** `in_key = db135345_f20a225c_d4d4d4d5_2d26314c`, mode 10 → `out_key = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8` at cycle c+5; columns update one per cycle, internally checked.
- **Bypass plus tag:** `in_key = 00112233_44556677_8899aabb_ccddeeff`, mode 00, tag 4'hA → identical key and `out_tag = 4'hA` at c+1. Repeat with mode 11 for the same result.
- **Backpressure:** hold `out_ready=0` for 5 cycles after `out_valid`. Required:
  - `out_key`/`out_tag` stable;
  - `in_ready=0`;
  - a raised `out_ready` with `in_valid=1` accepts the next key in the same cycle.
- **Reset mid-BUSY (LANES=1):** assert `rst_n=0` after 2 `BUSY` cycles. Required:
  - immediately `out_valid=0`, `out_key=0`, `in_ready=1` after release;
  - the next key produces a fully correct result.
- **Streaming:** 16 random keys with random modes and random `out_ready`, at LANES 1, 2 and 4. Check in-order results against a reference model, with no drops or duplicates.
